// File: rtl/adc_count_sequencer_if.sv
// Control, status and ADC-observation signals of adc_count_sequencer.
// The slave modport is the sequencer side; master is the controlling side.
interface adc_count_sequencer_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int LEN_WIDTH    = 16,
    parameter int GAP_WIDTH    = 8
);
    logic                    start;
    logic                    abort;
    logic [LEN_WIDTH-1:0]    burst_len;
    logic [7:0]              num_bursts;
    logic [GAP_WIDTH-1:0]    gap_len;
    logic                    restart_each;
    logic [NUM_CHANNELS-1:0] adc_enable_in;
    logic [NUM_CHANNELS-1:0] adc_valid_in;
    logic                    send_count;
    logic                    reset_count;
    logic                    busy;
    logic                    done;
    logic                    aborted;
    logic [7:0]              burst_index;
    logic [LEN_WIDTH-1:0]    beat_count;
    logic [2:0]              fsm_state;

    modport master (
        output start, abort, burst_len, num_bursts, gap_len, restart_each,
               adc_enable_in, adc_valid_in,
        input  send_count, reset_count, busy, done, aborted, burst_index,
               beat_count, fsm_state
    );

    modport slave (
        input  start, abort, burst_len, num_bursts, gap_len, restart_each,
               adc_enable_in, adc_valid_in,
        output send_count, reset_count, busy, done, aborted, burst_index,
               beat_count, fsm_state
    );
endinterface

// File: rtl/adc_count_sequencer.sv
// Drives send_count/reset_count of the ADC data-order stage through a programmed
// series of fixed-length counting bursts separated by passthrough gaps.
module adc_count_sequencer #(
    parameter int NUM_CHANNELS = 4,
    parameter int LEN_WIDTH    = 16,
    parameter int GAP_WIDTH    = 8
) (
    input  logic                 adc_clk,
    input  logic                 adc_rst,
    adc_count_sequencer_if.slave io
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]           state;
    logic [2:0]           next_state;
    logic [2:0]           resume_state;
    logic [LEN_WIDTH-1:0] cfg_len;
    logic [7:0]           cfg_num;
    logic [GAP_WIDTH-1:0] cfg_gap;
    logic                 cfg_restart;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic [LEN_WIDTH-1:0] beat_count;
    logic [7:0]           burst_index;
    logic [7:0]           burst_next;
    logic                 send_count;
    logic                 reset_count;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic                 beat;
    logic                 accept;
    logic                 stop;
    logic                 last_beat;
    logic                 last_burst;

    // start/abort are single-cycle strobes sampled on every edge: start is taken
    // only in IDLE with nonzero burst_len and no abort; abort acts only in ARM/RUN/GAP.
    assign beat         = |(io.adc_enable_in & io.adc_valid_in);
    assign accept       = io.start && !io.abort && (io.burst_len != '0);
    assign stop         = io.abort && ((state == S_ARM) || (state == S_RUN) || (state == S_GAP));
    assign last_beat    = (state == S_RUN) && beat && (beat_count == cfg_len - LEN_WIDTH'(1));
    assign burst_next   = burst_index + 8'd1;
    assign last_burst   = (cfg_num != 8'd0) && (burst_next == cfg_num);
    assign resume_state = cfg_restart ? S_ARM : S_RUN;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept) next_state = S_ARM;
            S_ARM:  next_state = S_RUN;
            S_RUN: begin
                if (last_beat) begin
                    if (last_burst)          next_state = S_DONE;
                    else if (cfg_gap != '0)  next_state = S_GAP;
                    else                     next_state = resume_state;
                end
            end
            S_GAP:  if (gap_cnt == GAP_WIDTH'(1)) next_state = resume_state;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (stop) next_state = S_DONE;
    end

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            state       <= S_IDLE;
            cfg_len     <= '0;
            cfg_num     <= '0;
            cfg_gap     <= '0;
            cfg_restart <= 1'b0;
            gap_cnt     <= '0;
            beat_count  <= '0;
            burst_index <= '0;
            send_count  <= 1'b0;
            reset_count <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state       <= next_state;
            send_count  <= (next_state == S_RUN);
            reset_count <= (next_state == S_ARM);
            busy        <= (next_state == S_ARM) || (next_state == S_RUN) || (next_state == S_GAP);
            done        <= (next_state == S_DONE);
            if (stop) aborted <= 1'b1;
            if ((state == S_IDLE) && accept) begin
                cfg_len     <= io.burst_len;
                cfg_num     <= io.num_bursts;
                cfg_gap     <= io.gap_len;
                cfg_restart <= io.restart_each;
                aborted     <= 1'b0;
                burst_index <= '0;
            end
            if (last_beat) burst_index <= burst_next;
            // A new burst always starts from zero, whether it comes via ARM or directly.
            if ((next_state == S_ARM) ||
                ((next_state == S_RUN) && (last_beat || (state == S_GAP)))) begin
                beat_count <= '0;
            end else if ((state == S_RUN) && beat) begin
                beat_count <= beat_count + LEN_WIDTH'(1);
            end
            if ((state == S_RUN) && (next_state == S_GAP)) gap_cnt <= cfg_gap;
            else if (state == S_GAP)                       gap_cnt <= gap_cnt - GAP_WIDTH'(1);
        end
    end

    assign io.send_count  = send_count;
    assign io.reset_count = reset_count;
    assign io.busy        = busy;
    assign io.done        = done;
    assign io.aborted     = aborted;
    assign io.burst_index = burst_index;
    assign io.beat_count  = beat_count;
    assign io.fsm_state   = state;
endmodule

// File: tb/tb_adc_count_sequencer.sv
// Directed bench for adc_count_sequencer: per-sequence summaries are queued at
// start and checked by a monitor on each done pulse, plus inline timing checks.
module tb_adc_count_sequencer;
    localparam int NC = 4;
    localparam int LW = 16;
    localparam int GW = 8;
    localparam int W  = 65;

    logic adc_clk = 1'b0;
    logic adc_rst = 1'b1;

    adc_count_sequencer_if #(.NUM_CHANNELS(NC), .LEN_WIDTH(LW), .GAP_WIDTH(GW)) io ();

    adc_count_sequencer #(.NUM_CHANNELS(NC), .LEN_WIDTH(LW), .GAP_WIDTH(GW)) dut (
        .adc_clk (adc_clk),
        .adc_rst (adc_rst),
        .io      (io)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_rec;
    int send_cyc  = 0;
    int rst_cyc   = 0;
    int busy_cyc  = 0;

    // clock / reset
    always #5 adc_clk = ~adc_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // record: send cycles, reset_count cycles, busy cycles, burst_index, beat_count, aborted
    function automatic logic [W-1:0] pack(input int s, input int r, input int b,
                                          input int bi, input int bc, input bit ab);
        return {16'(s), 8'(r), 16'(b), 8'(bi), 16'(bc), ab};
    endfunction

    function automatic bit pat_bit(input int pat, input int k);
        return (pat == 0) ? 1'b1 : ((k % 2) == 1);
    endfunction

    // monitor / scoreboard
    always @(negedge adc_clk) begin
        if (adc_rst) begin
            send_cyc = 0;
            rst_cyc  = 0;
            busy_cyc = 0;
        end else begin
            if (io.busy)        busy_cyc++;
            if (io.send_count)  send_cyc++;
            if (io.reset_count) rst_cyc++;
            if (io.done) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    exp_rec = exp_q.pop_front();
                    check("sb_send_cycles",  64'(send_cyc), 64'(exp_rec[64:49]));
                    check("sb_reset_cycles", 64'(rst_cyc),  64'(exp_rec[48:41]));
                    check("sb_busy_cycles",  64'(busy_cyc), 64'(exp_rec[40:25]));
                    check("sb_burst_index",  64'(io.burst_index), 64'(exp_rec[24:17]));
                    check("sb_beat_count",   64'(io.beat_count),  64'(exp_rec[16:1]));
                    check("sb_aborted",      64'(io.aborted),     64'(exp_rec[0]));
                    check("sb_busy_at_done", 64'(io.busy), 64'd0);
                end
                send_cyc = 0;
                rst_cyc  = 0;
                busy_cyc = 0;
            end
        end
    end

    // driver tasks
    task automatic cycle();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic run_seq(input int len, input int num, input int gap, input bit rs,
                           input logic [3:0] en, input int pat, input int abort_at,
                           input int restart_at, input logic [W-1:0] exp);
        int k;
        io.burst_len     = LW'(len);
        io.num_bursts    = 8'(num);
        io.gap_len       = GW'(gap);
        io.restart_each  = rs;
        io.adc_enable_in = en;
        io.adc_valid_in  = ~en;
        exp_q.push_back(exp);
        io.start = 1'b1;
        cycle();
        io.start = 1'b0;
        check("arm_reset_count", 64'(io.reset_count), 64'd1);
        check("arm_busy",        64'(io.busy),        64'd1);
        check("arm_send_count",  64'(io.send_count),  64'd0);
        k = 1;
        while (!io.done && k < 400) begin
            io.adc_valid_in = pat_bit(pat, k) ? en : ~en;
            io.abort = (k == abort_at);
            if (k == restart_at) begin
                io.start     = 1'b1;
                io.burst_len = LW'(8);
            end
            cycle();
            io.abort = 1'b0;
            io.start = 1'b0;
            if (k == 1) check("run_send_count", 64'(io.send_count), 64'd1);
            k++;
        end
        if (!io.done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL seq_timeout: got no done after %0d cycles expected done", k);
        end
        if (restart_at > 0) begin
            io.burst_len = LW'(2);
            io.start = 1'b1;
            cycle();
            io.start = 1'b0;
            check("start_in_done_busy", 64'(io.busy), 64'd0);
        end
        io.adc_valid_in = '0;
        cycle();
        cycle();
    endtask

    initial begin
        io.start         = 1'b0;
        io.abort         = 1'b0;
        io.burst_len     = '0;
        io.num_bursts    = '0;
        io.gap_len       = '0;
        io.restart_each  = 1'b0;
        io.adc_enable_in = '0;
        io.adc_valid_in  = '0;
        cycle();
        cycle();
        adc_rst = 1'b0;
        cycle();
        check("rst_send_count",  64'(io.send_count),  64'd0);
        check("rst_reset_count", 64'(io.reset_count), 64'd0);
        check("rst_busy",        64'(io.busy),        64'd0);
        check("rst_done",        64'(io.done),        64'd0);
        check("rst_aborted",     64'(io.aborted),     64'd0);
        check("rst_burst_index", 64'(io.burst_index), 64'd0);
        check("rst_beat_count",  64'(io.beat_count),  64'd0);
        check("rst_state",       64'(io.fsm_state),   64'd0);

        // single burst, valid always high on ch0
        run_seq(4, 1, 0, 1'b1, 4'b0001, 0, -1, -1, pack(4, 1, 5, 1, 4, 1'b0));
        // two bursts, gap 2, re-arm each, valid every other cycle on ch2
        run_seq(3, 2, 2, 1'b1, 4'b0100, 1, -1, -1, pack(11, 2, 15, 2, 3, 1'b0));
        // three back-to-back bursts without re-arm
        run_seq(2, 3, 0, 1'b0, 4'b0010, 0, -1, -1, pack(6, 1, 7, 3, 2, 1'b0));
        // abort on the second beat
        run_seq(10, 1, 0, 1'b1, 4'b0001, 0, 3, -1, pack(2, 1, 3, 0, 2, 1'b1));

        // ignored starts: zero length, start with abort
        io.burst_len = '0;
        io.start = 1'b1;
        cycle();
        io.start = 1'b0;
        check("zero_len_busy",  64'(io.busy),        64'd0);
        check("zero_len_reset", 64'(io.reset_count), 64'd0);
        cycle();
        check("zero_len_busy2", 64'(io.busy),        64'd0);
        io.burst_len = LW'(5);
        io.start = 1'b1;
        io.abort = 1'b1;
        cycle();
        io.start = 1'b0;
        io.abort = 1'b0;
        check("start_abort_busy",  64'(io.busy),      64'd0);
        check("start_abort_state", 64'(io.fsm_state), 64'd0);
        cycle();
        // start while busy and in the done cycle; aborted clears on the new start
        run_seq(3, 1, 0, 1'b1, 4'b0001, 0, -1, 2, pack(3, 1, 4, 1, 3, 1'b0));

        // continuous mode: burst_index wraps, then async reset mid-run
        io.burst_len     = LW'(1);
        io.num_bursts    = 8'd0;
        io.gap_len       = '0;
        io.restart_each  = 1'b0;
        io.adc_enable_in = 4'b0001;
        io.adc_valid_in  = 4'b0001;
        io.start = 1'b1;
        cycle();
        io.start = 1'b0;
        for (int k = 1; k <= 301; k++) begin
            if (k == 257) check("cont_index_255",  64'(io.burst_index), 64'd255);
            if (k == 258) check("cont_index_wrap", 64'(io.burst_index), 64'd0);
            cycle();
        end
        check("cont_index_300", 64'(io.burst_index), 64'd44);
        check("cont_send",      64'(io.send_count),  64'd1);
        check("cont_busy",      64'(io.busy),        64'd1);
        check("cont_beat",      64'(io.beat_count),  64'd0);
        #2;
        adc_rst = 1'b1;
        #1;
        check("arst_send_count",  64'(io.send_count),  64'd0);
        check("arst_reset_count", 64'(io.reset_count), 64'd0);
        check("arst_busy",        64'(io.busy),        64'd0);
        check("arst_done",        64'(io.done),        64'd0);
        check("arst_burst_index", 64'(io.burst_index), 64'd0);
        check("arst_state",       64'(io.fsm_state),   64'd0);
        cycle();
        cycle();
        adc_rst = 1'b0;
        io.adc_valid_in = '0;
        cycle();
        cycle();
        check("post_arst_busy", 64'(io.busy), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
